// File: rtl/hpdmc_ddr_pkg.sv
// Shared types and elaboration helpers for the HPDMC DDR write/read datapath.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package hpdmc_ddr_pkg;

  // Write-burst sequencer states.
  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_PRE  = 2'd1,
    WR_DATA = 2'd2,
    WR_POST = 2'd3
  } wr_state_t;

  // Only BL2/BL4/BL8 map onto whole DDR clock cycles.
  function automatic bit burst_len_ok(input int bl);
    return (bl == 2) || (bl == 4) || (bl == 8);
  endfunction

  // Byte lanes (DM/DQS pins) for a given DQ width.
  function automatic int strobe_width(input int dq_width);
    return dq_width / 8;
  endfunction

  // Width of a whole burst of DQ beats.
  function automatic int burst_data_width(input int dq_width, input int bl);
    return dq_width * bl;
  endfunction

  // Width of a whole burst of byte masks.
  function automatic int burst_mask_width(input int dq_width, input int bl);
    return (dq_width / 8) * bl;
  endfunction

  // Beat-pair counter width; at least one bit even for BL2.
  function automatic int beat_cnt_width(input int bl);
    return (bl / 2 > 1) ? $clog2(bl / 2) : 1;
  endfunction

endpackage

// File: rtl/hpdmc_burst_fifo.sv
// Generic synchronous FIFO with occupancy count; read data is the head entry.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; caller uses full/empty.
//
// Ports: clk/rst_n (async active-low), push/push_dat, pop/pop_dat (head, combinational
// from storage), full, empty, level (0..DEPTH).
module hpdmc_burst_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

  // Storage needs no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/hpdmc_wrburst_oddr.sv
// Write-burst serialiser: buffers whole bursts, plays them out as D0/D1 pairs for DQ/DM/DQS ODDR2s.
// Latency: wr_start at t -> preamble at t+1, data t+2..t+1+BL/2, postamble after; bursts chain gaplessly.
// Backpressure: in_ready = !full (from registered FIFO state); wr_start on empty/busy flags a sticky error.
//
// Ports: sys_clk, sys_rst_n (async active-low); in_valid/in_ready/in_data/in_mask burst push;
// wr_start scheduler strobe; err_clr; dq_d0/d1, dm_d0/d1, dqs_d0/d1 edge data; dq_oe, dqs_oe;
// busy; fifo_level; err_underrun, err_overlap.
module hpdmc_wrburst_oddr
  import hpdmc_ddr_pkg::*;
#(
  parameter int DQ_WIDTH   = 16,
  parameter int BURST_LEN  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DQ_WIDTH*BURST_LEN-1:0]     in_data,
  input  logic [DQ_WIDTH/8*BURST_LEN-1:0]   in_mask,
  input  logic                              wr_start,
  input  logic                              err_clr,
  output logic [DQ_WIDTH-1:0]               dq_d0,
  output logic [DQ_WIDTH-1:0]               dq_d1,
  output logic [DQ_WIDTH/8-1:0]             dm_d0,
  output logic [DQ_WIDTH/8-1:0]             dm_d1,
  output logic [DQ_WIDTH/8-1:0]             dqs_d0,
  output logic [DQ_WIDTH/8-1:0]             dqs_d1,
  output logic                              dq_oe,
  output logic                              dqs_oe,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic                              err_underrun,
  output logic                              err_overlap
);

  localparam int DQS_W  = strobe_width(DQ_WIDTH);
  localparam int DATA_W = burst_data_width(DQ_WIDTH, BURST_LEN);
  localparam int MASK_W = burst_mask_width(DQ_WIDTH, BURST_LEN);
  localparam int FIFO_W = DATA_W + MASK_W;
  localparam int CYCLES = BURST_LEN / 2;
  localparam int CNT_W  = beat_cnt_width(BURST_LEN);

  if (!burst_len_ok(BURST_LEN)) begin : g_bad_burst_len
    $error("hpdmc_wrburst_oddr: BURST_LEN must be 2, 4 or 8");
  end
  if ((DQ_WIDTH % 8) != 0 || DQ_WIDTH < 8) begin : g_bad_dq_width
    $error("hpdmc_wrburst_oddr: DQ_WIDTH must be a non-zero multiple of 8");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("hpdmc_wrburst_oddr: FIFO_DEPTH must be a power of two >= 2");
  end

  wr_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_beat;
  logic              pop_vld;
  logic              chain;
  logic              set_underrun;
  logic              set_overlap;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FIFO_W-1:0] fifo_rd_dat;
  logic [DATA_W-1:0] head_dat, shreg_dat, src_dat;
  logic [MASK_W-1:0] head_msk, shreg_msk, src_msk;

  assign in_ready  = !fifo_full;
  assign head_dat  = fifo_rd_dat[DATA_W-1:0];
  assign head_msk  = fifo_rd_dat[FIFO_W-1:DATA_W];
  assign last_beat = (cnt_q == CNT_W'(CYCLES - 1));
  // The DDR strobe falls on every C1 edge, so the falling-edge pattern is constant.
  assign dqs_d1    = '0;

  hpdmc_burst_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .push     (in_valid && in_ready),
    .push_dat ({in_mask, in_data}),
    .pop      (pop_vld),
    .pop_dat  (fifo_rd_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    pop_vld      = 1'b0;
    chain        = 1'b0;
    set_underrun = 1'b0;
    set_overlap  = 1'b0;
    case (state_q)
      WR_IDLE: begin
        if (wr_start) begin
          if (!fifo_empty) begin
            pop_vld = 1'b1;
            state_d = WR_PRE;
          end else begin
            set_underrun = 1'b1;
          end
        end
      end
      WR_PRE: begin
        state_d     = WR_DATA;
        set_overlap = wr_start;
      end
      WR_DATA: begin
        if (!last_beat) begin
          cnt_d       = cnt_q + 1'b1;
          set_overlap = wr_start;
        end else if (wr_start && !fifo_empty) begin
          // Gapless chain: stay in DATA, restart at beat pair 0 from the new head.
          pop_vld = 1'b1;
          chain   = 1'b1;
        end else begin
          state_d      = WR_POST;
          set_underrun = wr_start;
        end
      end
      WR_POST: begin
        state_d     = WR_IDLE;
        set_overlap = wr_start;
      end
      default: state_d = WR_IDLE;
    endcase
    // On a chained burst the first pair comes straight from the FIFO head,
    // since the shift register still holds the tail of the previous burst.
    src_dat = chain ? head_dat : shreg_dat;
    src_msk = chain ? head_msk : shreg_msk;
  end

  // Outputs are registered from the next state so each reflects the state it is shown in.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= WR_IDLE;
      cnt_q        <= '0;
      shreg_dat    <= '0;
      shreg_msk    <= '0;
      dq_d0        <= '0;
      dq_d1        <= '0;
      dm_d0        <= '0;
      dm_d1        <= '0;
      dqs_d0       <= '0;
      dq_oe        <= 1'b0;
      dqs_oe       <= 1'b0;
      busy         <= 1'b0;
      err_underrun <= 1'b0;
      err_overlap  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;

      if (pop_vld && !chain) begin
        shreg_dat <= head_dat;
        shreg_msk <= head_msk;
      end else if (state_d == WR_DATA) begin
        shreg_dat <= src_dat >> (2 * DQ_WIDTH);
        shreg_msk <= src_msk >> (2 * DQS_W);
      end

      if (state_d == WR_DATA) begin
        dq_d0 <= src_dat[0 +: DQ_WIDTH];
        dq_d1 <= src_dat[DQ_WIDTH +: DQ_WIDTH];
        dm_d0 <= src_msk[0 +: DQS_W];
        dm_d1 <= src_msk[DQS_W +: DQS_W];
      end else begin
        dq_d0 <= '0;
        dq_d1 <= '0;
        dm_d0 <= '0;
        dm_d1 <= '0;
      end

      dqs_d0 <= {DQS_W{state_d == WR_DATA}};
      dq_oe  <= (state_d == WR_DATA);
      dqs_oe <= (state_d != WR_IDLE);
      busy   <= (state_d != WR_IDLE);

      // A new error in the same cycle as a clear wins.
      err_underrun <= set_underrun | (err_underrun & ~err_clr);
      err_overlap  <= set_overlap  | (err_overlap  & ~err_clr);
    end
  end

endmodule

// File: doc/hpdmc_wrburst_oddr.md
# hpdmc_wrburst_oddr

Parametrised write-burst serialiser for the HPDMC DDR datapath. It buffers complete write bursts from the controller, then on a scheduler strobe plays them out as per-cycle rising/falling-edge pairs (D0/D1) for the DQ, DM and DQS ODDR2 banks. It also generates the DQ/DQS output enables with preamble and postamble. It replaces fixed-width output-register banks with a generic width, burst length and buffer depth, and it supports gapless back-to-back bursts and error reporting.

## Interface
Parameters:
- DQ_WIDTH, 16: DQ pins; multiple of 8; DM and DQS width = DQ_WIDTH/8.
- BURST_LEN, 4: beats per burst; 2, 4 or 8; data phase lasts BURST_LEN/2 cycles.
- FIFO_DEPTH, 4: buffered bursts; power of two, ≥2.

Ports:
- sys_clk  in  1  single clock; ODDR2 C0 domain.
- sys_rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  burst word offered.
- in_ready  out  1  high when FIFO not full.
- in_data  in  DQ_WIDTH*BURST_LEN  beat k = bits [k*DQ_WIDTH +: DQ_WIDTH].
- in_mask  in  DQ_WIDTH/8*BURST_LEN  byte masks, same beat ordering.
- wr_start  in  1  scheduler strobe: start next burst.
- err_clr  in  1  clears sticky error flags.
- dq_d0, dq_d1  out  DQ_WIDTH each  rising/falling-edge DQ data.
- dm_d0, dm_d1  out  DQ_WIDTH/8 each  rising/falling-edge masks.
- dqs_d0, dqs_d1  out  DQ_WIDTH/8 each  strobe pattern.
- dq_oe, dqs_oe  out  1 each  output enables (active high).
- busy  out  1  FSM not IDLE.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  buffered burst count.
- err_underrun, err_overlap  out  1 each  sticky error flags.

## Operation
- Push occurs when in_valid && in_ready. in_ready = !full is combinational from registered state.
- FSM states: IDLE, PRE, DATA, POST.
- IDLE + wr_start + FIFO non-empty:
  - pop the head entry into the shift register;
  - go to PRE.
- IDLE + wr_start + FIFO empty: stay in IDLE; set err_underrun.
- PRE:
  - dqs_oe=1, dqs_d0=dqs_d1=0, dq_oe=0;
  - next state DATA, beat counter = 0.
- DATA, cycle c (0..BURST_LEN/2-1):
  - dq_d0 = beat 2c, dq_d1 = beat 2c+1; dm likewise;
  - dqs_d0=1, dqs_d1=0, dq_oe=1, dqs_oe=1.
- Last DATA cycle + wr_start + FIFO non-empty:
  - pop the next entry; re-enter DATA at c=0 with no PRE/POST (gapless).
- Last DATA cycle + wr_start + FIFO empty: set err_underrun; go to POST.
- Last DATA cycle, no wr_start: go to POST.
- wr_start in PRE, POST or a non-last DATA cycle: ignored; set err_overlap.
- POST:
  - dqs_oe=1, dqs_d0=dqs_d1=0, dq_oe=0;
  - next state IDLE.
- Outside DATA: dq_d*/dm_d* hold 0.
- Error flags: err_clr clears both. If a set and a clear happen in the same cycle, set wins.
- Simultaneous push and pop: both take effect; fifo_level unchanged. Push while full is impossible because in_ready=0.

## Timing
- All outputs registered. Reset values: every output 0 except in_ready=1; fifo_level=0; FSM=IDLE; FIFO pointers 0.
- wr_start in cycle t: PRE in t+1; DATA in t+2..t+1+BURST_LEN/2; POST in the next cycle; IDLE after that. Busy spans PRE through POST.
- Gapless chaining: the DATA stream continues with no idle cycle between bursts.
- Pop takes effect at the wr_start edge: fifo_level drops one cycle after wr_start. in_ready rises the same cycle if the FIFO was full.
- Push takes effect in the next cycle: fifo_level increments one cycle after the handshake. A pushed entry is eligible for a wr_start in the following cycle.
- Reset mid-burst: outputs, including the enables, go to 0 asynchronously. Buffered data is discarded.

## Structure
- Package hpdmc_ddr_pkg holds:
  - FSM state enum;
  - BURST_LEN legality check;
  - helper functions for beat/mask slice widths.
- Sub-module hpdmc_burst_fifo: synchronous FIFO with parametrised width/depth; provides full, empty and level. Shared later with the read path.
- The ODDR2 banks are instantiated by the parent PHY, not in this block.

## Test plan
- Reset, then push one burst (DQ_WIDTH=16, BURST_LEN=4) with data beats 0x1111/0x2222/0x3333/0x4444 and mask 0. Pulse wr_start at t:
  - PRE at t+1;
  - t+2: dq_d0=0x1111, dq_d1=0x2222;
  - t+3: dq_d0=0x3333, dq_d1=0x4444;
  - POST at t+4; IDLE at t+5; dq_oe high only at t+2..t+3.
- Push two bursts; pulse wr_start at t and at t+3 (last DATA cycle):
  - four consecutive DATA cycles;
  - one PRE and one POST only;
  - no errors.
- wr_start with empty FIFO → no PRE, err_underrun=1. err_clr → 0. err_clr together with a new underrun → stays 1.
- Fill FIFO_DEPTH=4:
  - in_ready=0 and fifo_level=4;
  - wr_start → in_ready=1 the next cycle; a push the same cycle keeps level at 4.
- wr_start during PRE → ignored, err_overlap=1, burst output unchanged.
- Assert sys_rst_n=0 mid-DATA → all outputs 0 immediately, fifo_level=0. After release, in_ready=1.
